// File: rtl/reg_bank_arbiter.sv
// Two-requester round-robin controller for the 16xDW register bank.
// One command in flight at a time; read data is returned to the issuing requester.
module reg_bank_arbiter #(
    parameter int DW     = 64,
    parameter int RW     = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          req0_valid,
    output logic          req0_ready,
    input  logic          req0_wr,
    input  logic [RW-1:0] req0_wreg,
    input  logic [1:0]    req0_endreg,
    input  logic [DW-1:0] req0_data,
    input  logic [RW-1:0] req0_rA,
    input  logic [RW-1:0] req0_rB,
    input  logic [1:0]    req0_cnst,
    input  logic          req1_valid,
    output logic          req1_ready,
    input  logic          req1_wr,
    input  logic [RW-1:0] req1_wreg,
    input  logic [1:0]    req1_endreg,
    input  logic [DW-1:0] req1_data,
    input  logic [RW-1:0] req1_rA,
    input  logic [RW-1:0] req1_rB,
    input  logic [1:0]    req1_cnst,
    output logic          rsp0_valid,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp_dataA,
    output logic [DW-1:0] rsp_dataB,
    output logic          rb_regwen,
    output logic [DW-1:0] rb_inA,
    output logic [RW-1:0] rb_selwreg,
    output logic [1:0]    rb_endreg,
    output logic [RW-1:0] rb_seloutA,
    output logic [RW-1:0] rb_seloutB,
    output logic          rb_cnstA,
    output logic          rb_cnstB,
    output logic          rb_enrregA,
    output logic          rb_enrregB,
    input  logic [DW-1:0] rb_outA,
    input  logic [DW-1:0] rb_outB
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WR   = 3'd1,
        RD   = 3'd2,
        WAIT = 3'd3,
        RSP  = 3'd4
    } stateT;

    localparam logic [2:0] LAST_WAIT = 3'(RD_LAT - 1);

    stateT         state;
    stateT         nextState;
    logic          lastGrant;
    logic          grant;
    logic          accept;
    logic          owner;
    logic [2:0]    waitCnt;
    logic          waitDone;
    logic          selWr;
    logic [RW-1:0] selWreg;
    logic [1:0]    selEndreg;
    logic [DW-1:0] selData;
    logic [RW-1:0] selRA;
    logic [RW-1:0] selRB;
    logic [1:0]    selCnst;

    // Round-robin grant: on contention the requester not served last time wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~lastGrant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end else begin
            grant = 1'b0;
        end
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign waitDone   = (state == WAIT) && (waitCnt == LAST_WAIT);

    // Command field mux for the granted requester.
    always_comb begin
        selWr     = req0_wr;
        selWreg   = req0_wreg;
        selEndreg = req0_endreg;
        selData   = req0_data;
        selRA     = req0_rA;
        selRB     = req0_rB;
        selCnst   = req0_cnst;
        if (grant) begin
            selWr     = req1_wr;
            selWreg   = req1_wreg;
            selEndreg = req1_endreg;
            selData   = req1_data;
            selRA     = req1_rA;
            selRB     = req1_rB;
            selCnst   = req1_cnst;
        end else begin
            selWr     = req0_wr;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    nextState = selWr ? WR : RD;
                end else begin
                    nextState = IDLE;
                end
            end
            WR:   nextState = IDLE;
            RD:   nextState = WAIT;
            WAIT: begin
                if (waitDone) begin
                    nextState = RSP;
                end else begin
                    nextState = WAIT;
                end
            end
            RSP:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Arbitration pointer, response owner and read-latency counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lastGrant <= 1'b1;
            owner     <= 1'b0;
            waitCnt   <= 3'd0;
        end else begin
            if (accept) begin
                lastGrant <= grant;
                owner     <= grant;
            end
            if (state == WAIT && !waitDone) begin
                waitCnt <= waitCnt + 3'd1;
            end else begin
                waitCnt <= 3'd0;
            end
        end
    end

    // Bank strobes and fields; strobes are set on the accept edge so they are
    // high exactly during WR/RD, while indices and data hold between commands.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rb_regwen  <= 1'b0;
            rb_inA     <= '0;
            rb_selwreg <= '0;
            rb_endreg  <= 2'b00;
            rb_seloutA <= '0;
            rb_seloutB <= '0;
            rb_cnstA   <= 1'b0;
            rb_cnstB   <= 1'b0;
            rb_enrregA <= 1'b0;
            rb_enrregB <= 1'b0;
        end else begin
            rb_regwen  <= accept && selWr;
            rb_enrregA <= accept && !selWr;
            rb_enrregB <= accept && !selWr;
            if (accept && selWr) begin
                rb_inA     <= selData;
                rb_selwreg <= selWreg;
                rb_endreg  <= selEndreg;
            end
            if (accept && !selWr) begin
                rb_seloutA <= selRA;
                rb_seloutB <= selRB;
                rb_cnstA   <= selCnst[0];
                rb_cnstB   <= selCnst[1];
            end
        end
    end

    // Read response capture and one-cycle valid pulse to the owner.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_dataA  <= '0;
            rsp_dataB  <= '0;
        end else begin
            rsp0_valid <= waitDone && !owner;
            rsp1_valid <= waitDone && owner;
            if (waitDone) begin
                rsp_dataA <= rb_outA;
                rsp_dataB <= rb_outB;
            end
        end
    end

endmodule
